// File: rtl/vga_scan_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// vga_scan_ctrl
//
// Raster-scan timing source for the graphics renderer. Generates 640x480@60
// VGA timing from a fast system clock divided down to the pixel rate, hands
// the renderer the pixel coordinate to fetch, samples its colour reply at the
// end of every pixel slot, blanks it outside the visible area and drives the
// result to the DAC pins together with matching sync and data-enable.
//
// Ports
//   clk            in   1   system clock, all logic on posedge
//   rst            in   1   asynchronous reset, active-high
//   i_r,i_g,i_b    in   4   renderer colour for the coordinate on o_x_read/o_y_read
//   o_x_read       out  10  horizontal scan counter (0..H_TOTAL-1)
//   o_y_read       out  10  vertical scan counter (0..V_TOTAL-1)
//   o_r,o_g,o_b    out  4   registered pixel colour, zero while blanked
//   o_hs,o_vs      out  1   registered sync, asserted level is SYNC_POL
//   o_de           out  1   registered: displayed pixel lies in the active area
//   o_frame_start  out  1   one-clk pulse when the scan wraps to (0,0)
//
// Pipeline
//   p0: clock divider and h/v scan counters (the coordinate being fetched)
//   p1: output registers; they capture the slot that is ending, so the pins
//       lag the coordinates by exactly one pixel slot.
// ---------------------------------------------------------------------------
module vga_scan_ctrl #(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] i_r,
    input  logic [3:0] i_g,
    input  logic [3:0] i_b,
    output logic [9:0] o_x_read,
    output logic [9:0] o_y_read,
    output logic [3:0] o_r,
    output logic [3:0] o_g,
    output logic [3:0] o_b,
    output logic       o_hs,
    output logic       o_vs,
    output logic       o_de,
    output logic       o_frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);

    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    // ---------------------------------------------------------------- p0
    logic [DIV_W-1:0] div_cnt_p0;
    logic [9:0]       h_cnt_p0;
    logic [9:0]       v_cnt_p0;

    logic tick_p0;
    logic h_last_p0;
    logic v_last_p0;
    logic active_p0;
    logic hs_win_p0;
    logic vs_win_p0;

    // tick marks the last clk of a pixel slot; the renderer reply has been
    // stable since 2 clk after the coordinate changed, so it is sampled here.
    assign tick_p0   = (div_cnt_p0 == DIV_LAST);
    assign h_last_p0 = (h_cnt_p0 == H_LAST);
    assign v_last_p0 = (v_cnt_p0 == V_LAST);
    assign active_p0 = (h_cnt_p0 < H_ACT) && (v_cnt_p0 < V_ACT);
    assign hs_win_p0 = (h_cnt_p0 >= HS_START) && (h_cnt_p0 < HS_END);
    assign vs_win_p0 = (v_cnt_p0 >= VS_START) && (v_cnt_p0 < VS_END);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_p0 <= '0;
        end else if (tick_p0) begin
            div_cnt_p0 <= '0;
        end else begin
            div_cnt_p0 <= div_cnt_p0 + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt_p0 <= '0;
            v_cnt_p0 <= '0;
        end else if (tick_p0) begin
            if (h_last_p0) begin
                h_cnt_p0 <= '0;
                if (v_last_p0) begin
                    v_cnt_p0 <= '0;
                end else begin
                    v_cnt_p0 <= v_cnt_p0 + 10'd1;
                end
            end else begin
                h_cnt_p0 <= h_cnt_p0 + 10'd1;
            end
        end
    end

    assign o_x_read = h_cnt_p0;
    assign o_y_read = v_cnt_p0;

    // ---------------------------------------------------------------- p1
    logic [11:0] rgb_p1;
    logic        vld_p1;
    logic        hs_p1;
    logic        vs_p1;
    logic        frame_start_p1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rgb_p1         <= 12'h000;
            vld_p1         <= 1'b0;
            hs_p1          <= ~SYNC_POL;
            vs_p1          <= ~SYNC_POL;
            frame_start_p1 <= 1'b0;
        end else begin
            // Pulse lasts only the clk after the wrapping tick.
            frame_start_p1 <= tick_p0 && h_last_p0 && v_last_p0;
            if (tick_p0) begin
                rgb_p1 <= active_p0 ? {i_r, i_g, i_b} : 12'h000;
                vld_p1 <= active_p0;
                hs_p1  <= hs_win_p0 ? SYNC_POL : ~SYNC_POL;
                vs_p1  <= vs_win_p0 ? SYNC_POL : ~SYNC_POL;
            end
        end
    end

    assign o_r           = rgb_p1[11:8];
    assign o_g           = rgb_p1[7:4];
    assign o_b           = rgb_p1[3:0];
    assign o_de          = vld_p1;
    assign o_hs          = hs_p1;
    assign o_vs          = vs_p1;
    assign o_frame_start = frame_start_p1;

endmodule

// File: tb/tb_vga_scan_ctrl.sv
`timescale 1ns/1ps
// Bench for vga_scan_ctrl. Instance A uses the real 640x480 timing and a
// renderer model that answers {x[3:0],y[3:0],4'h5} two clk after the
// coordinate. Instance B uses a shrunk 16x8 raster (8x4 visible) with a
// constant red input so whole-frame behaviour fits in a short run.
// Small raster: H 8+2+3+3=16, V 4+1+2+1=8, 4 clk per slot, 512 clk per frame.
// Pixel (h,v) reaches the pins on edge 4*(v*H_TOTAL+h+1) after reset release.
module tb_vga_scan_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Instance A: default timing
    logic [9:0]  xa, ya;
    logic [3:0]  ra, ga, ba;
    logic        hsa, vsa, dea, fsa;
    logic [11:0] rend_p1, rend_p2;

    always @(posedge clk) begin
        rend_p1 <= {xa[3:0], ya[3:0], 4'h5};
        rend_p2 <= rend_p1;
    end

    vga_scan_ctrl dut_a (
        .clk(clk), .rst(rst),
        .i_r(rend_p2[11:8]), .i_g(rend_p2[7:4]), .i_b(rend_p2[3:0]),
        .o_x_read(xa), .o_y_read(ya),
        .o_r(ra), .o_g(ga), .o_b(ba),
        .o_hs(hsa), .o_vs(vsa), .o_de(dea), .o_frame_start(fsa)
    );

    // Instance B: shrunk raster, constant red
    logic [11:0] rgb_b_in = 12'hF00;
    logic [9:0]  xb, yb;
    logic [3:0]  rb, gb, bb;
    logic        hsb, vsb, deb, fsb;

    vga_scan_ctrl #(
        .CLK_DIV(4), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b0)
    ) dut_b (
        .clk(clk), .rst(rst),
        .i_r(rgb_b_in[11:8]), .i_g(rgb_b_in[7:4]), .i_b(rgb_b_in[3:0]),
        .o_x_read(xb), .o_y_read(yb),
        .o_r(rb), .o_g(gb), .o_b(bb),
        .o_hs(hsb), .o_vs(vsb), .o_de(deb), .o_frame_start(fsb)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to the negedge following posedge number 'target' since release.
    task automatic run_to(input int target);
        while (cyc < target) begin
            @(posedge clk);
            cyc++;
        end
        @(negedge clk);
    endtask

    initial begin
        // ---- power-on reset
        repeat (3) @(negedge clk);
        chk("rst_x_a",  12'(xa), 12'd0);
        chk("rst_y_a",  12'(ya), 12'd0);
        chk("rst_rgb_a", {ra, ga, ba}, 12'h000);
        chk("rst_de_a", 12'(dea), 12'd0);
        chk("rst_hs_a", 12'(hsa), 12'd1);
        chk("rst_vs_a", 12'(vsa), 12'd1);
        chk("rst_fs_a", 12'(fsa), 12'd0);
        rst = 1'b0;
        cyc = 0;

        // ---- first slot after release
        run_to(3);
        chk("first_de_early_a", 12'(dea), 12'd0);
        chk("first_x_hold_a",   12'(xa),  12'd0);
        run_to(4);
        chk("first_de_a",  12'(dea), 12'd1);
        chk("first_rgb_a", {ra, ga, ba}, 12'h005);
        chk("first_x_a",   12'(xa), 12'd1);
        chk("first_de_b",  12'(deb), 12'd1);
        chk("first_rgb_b", {rb, gb, bb}, 12'hF00);

        // ---- small raster: horizontal active edge and hsync window
        run_to(32);
        chk("b_last_act_de",  12'(deb), 12'd1);
        chk("b_last_act_rgb", {rb, gb, bb}, 12'hF00);
        run_to(36);
        chk("b_hblank_de",  12'(deb), 12'd0);
        chk("b_hblank_rgb", {rb, gb, bb}, 12'h000);
        run_to(43);
        chk("b_hs_before", 12'(hsb), 12'd1);
        run_to(44);
        chk("b_hs_start", 12'(hsb), 12'd0);
        run_to(55);
        chk("b_hs_last", 12'(hsb), 12'd0);
        run_to(56);
        chk("b_hs_end", 12'(hsb), 12'd1);

        // ---- small raster: vertical blank and vsync window
        run_to(224);
        chk("b_last_line_de",  12'(deb), 12'd1);
        chk("b_last_line_rgb", {rb, gb, bb}, 12'hF00);
        run_to(256);
        chk("b_line3_hblank_de", 12'(deb), 12'd0);
        run_to(260);
        chk("b_vblank_de",  12'(deb), 12'd0);
        chk("b_vblank_rgb", {rb, gb, bb}, 12'h000);
        run_to(323);
        chk("b_vs_before", 12'(vsb), 12'd1);
        run_to(324);
        chk("b_vs_start", 12'(vsb), 12'd0);
        run_to(451);
        chk("b_vs_last", 12'(vsb), 12'd0);
        run_to(452);
        chk("b_vs_end", 12'(vsb), 12'd1);

        // ---- small raster: frame wrap
        run_to(511);
        chk("b_wrap_fs_pre", 12'(fsb), 12'd0);
        chk("b_wrap_x_pre",  12'(xb),  12'd15);
        chk("b_wrap_y_pre",  12'(yb),  12'd7);
        run_to(512);
        chk("b_wrap_fs", 12'(fsb), 12'd1);
        chk("b_wrap_x",  12'(xb),  12'd0);
        chk("b_wrap_y",  12'(yb),  12'd0);
        chk("b_wrap_de", 12'(deb), 12'd0);
        run_to(513);
        chk("b_wrap_fs_width", 12'(fsb), 12'd0);
        run_to(516);
        chk("b_frame2_de", 12'(deb), 12'd1);
        run_to(1024);
        chk("b_fs_period", 12'(fsb), 12'd1);

        // ---- full timing: active edge, hsync position, width and period
        run_to(2560);
        chk("a_px639_de",  12'(dea), 12'd1);
        chk("a_px639_rgb", {ra, ga, ba}, 12'hF05);
        run_to(2564);
        chk("a_px640_de",  12'(dea), 12'd0);
        chk("a_px640_rgb", {ra, ga, ba}, 12'h000);
        run_to(2627);
        chk("a_hs_before", 12'(hsa), 12'd1);
        run_to(2628);
        chk("a_hs_start", 12'(hsa), 12'd0);
        run_to(3011);
        chk("a_hs_last", 12'(hsa), 12'd0);
        run_to(3012);
        chk("a_hs_end", 12'(hsa), 12'd1);
        chk("a_vs_idle", 12'(vsa), 12'd1);
        chk("a_fs_idle", 12'(fsa), 12'd0);
        run_to(5827);
        chk("a_hs2_before", 12'(hsa), 12'd1);
        run_to(5828);
        chk("a_hs2_start", 12'(hsa), 12'd0);

        // ---- renderer latency: pixel (5,7) reaches the pins one slot later
        run_to(22423);
        chk("a_lat_prev", {ra, ga, ba}, 12'h475);
        run_to(22424);
        chk("a_lat_rgb", {ra, ga, ba}, 12'h575);
        chk("a_lat_x",   12'(xa), 12'd6);
        chk("a_lat_y",   12'(ya), 12'd7);

        // ---- asynchronous reset in the middle of a line
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_x_a",   12'(xa), 12'd0);
        chk("mid_rst_y_a",   12'(ya), 12'd0);
        chk("mid_rst_rgb_a", {ra, ga, ba}, 12'h000);
        chk("mid_rst_de_a",  12'(dea), 12'd0);
        chk("mid_rst_hs_a",  12'(hsa), 12'd1);
        chk("mid_rst_vs_a",  12'(vsa), 12'd1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        run_to(3);
        chk("re_de_early_a", 12'(dea), 12'd0);
        run_to(4);
        chk("re_de_a",  12'(dea), 12'd1);
        chk("re_rgb_a", {ra, ga, ba}, 12'h005);
        chk("re_de_b",  12'(deb), 12'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
